chnlnk_frame_ctrl: RTL

Parametrised channel-link frame sequencer. It reads sample data words from the channel FIFO and frames them with a fixed tail of CRC/trailer slots, producing one frame per sample. Samples are chained until end-of-event, and an event's final frame is followed by a single LAST_WRD cycle. This generation adds configurable frame geometry, downstream backpressure, FIFO-underrun stalling, sticky end-of-event capture and a per-event sample limit with truncation flag.

---
 rtl/chnlnk_frame_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/chnlnk_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : chnlnk_frame_ctrl
// Description : Channel-link frame sequencer; frames FIFO samples with a fixed
//               CRC/trailer tail and closes each event with a LAST_WRD strobe.
// Revision    : 2.0 - configurable geometry, backpressure, sample limit
// ============================================================================
module chnlnk_frame_ctrl #(
    parameter int DATA_WORDS  = 96,
    parameter int TAIL_WORDS  = 4,
    parameter int SEQ_W       = 7,
    parameter int MAX_SAMPLES = 16,
    parameter int SCNT_W      = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              L1A_BUF_MT,
    input  logic              F_MT,
    input  logic              END_EVT,
    input  logic              TX_RDY,
    output logic              RD,
    output logic              VALID,
    output logic [SEQ_W-1:0]  SEQ,
    output logic              CLR_CRC,
    output logic              LAST_WRD,
    output logic              TRUNC,
    output logic [SCNT_W-1:0] SAMP_CNT,
    output logic [2:0]        FRM_STATE
);

    localparam logic [2:0] C_IDLE        = 3'd0;
    localparam logic [2:0] C_LAST_WORD   = 3'd1;
    localparam logic [2:0] C_READ        = 3'd2;
    localparam logic [2:0] C_STRT_SAMPLE = 3'd3;
    localparam logic [2:0] C_TAIL_END    = 3'd4;
    localparam logic [2:0] C_TAIL_NO_END = 3'd5;
    localparam logic [2:0] C_W4DATA      = 3'd6;

    localparam logic [SEQ_W-1:0]  C_SEQ_LAST_DATA = SEQ_W'(DATA_WORDS - 1);
    localparam logic [SEQ_W-1:0]  C_SEQ_LAST_TAIL = SEQ_W'(DATA_WORDS + TAIL_WORDS - 1);
    localparam logic [SEQ_W-1:0]  C_SEQ_ONE       = SEQ_W'(1);
    localparam logic [SCNT_W-1:0] C_SCNT_LAST     = SCNT_W'(MAX_SAMPLES - 1);
    localparam logic [SCNT_W-1:0] C_SCNT_ONE      = SCNT_W'(1);

    logic [2:0]        state_q, state_d;
    logic [SEQ_W-1:0]  seq_q, seq_d;
    logic [SCNT_W-1:0] samp_cnt_q, samp_cnt_d;
    logic              end_flag_q, end_flag_d;
    logic              rd_q, rd_d;
    logic              valid_q, valid_d;
    logic              clr_crc_q, clr_crc_d;
    logic              last_wrd_q, last_wrd_d;
    logic              trunc_q, trunc_d;

    logic w_in_tail;
    logic w_in_data;
    logic w_tail_done;
    logic w_end_now;
    logic w_data_stall;

    assign w_in_tail    = (state_q == C_TAIL_END) || (state_q == C_TAIL_NO_END);
    assign w_in_data    = (state_q == C_STRT_SAMPLE) || (state_q == C_READ);
    assign w_tail_done  = w_in_tail && (seq_q == C_SEQ_LAST_TAIL);
    assign w_data_stall = F_MT || !TX_RDY;
    // The event closes on a marker seen now or earlier, or when this frame hits the limit.
    assign w_end_now    = end_flag_q || END_EVT || (samp_cnt_q == C_SCNT_LAST);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= C_IDLE;
            seq_q      <= '0;
            samp_cnt_q <= '0;
            end_flag_q <= 1'b0;
            rd_q       <= 1'b0;
            valid_q    <= 1'b0;
            clr_crc_q  <= 1'b0;
            last_wrd_q <= 1'b0;
            trunc_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            seq_q      <= seq_d;
            samp_cnt_q <= samp_cnt_d;
            end_flag_q <= end_flag_d;
            rd_q       <= rd_d;
            valid_q    <= valid_d;
            clr_crc_q  <= clr_crc_d;
            last_wrd_q <= last_wrd_d;
            trunc_q    <= trunc_d;
        end
    end

    always_comb begin
        state_d = 3'bxxx;
        case (state_q)
            C_IDLE:        state_d = L1A_BUF_MT ? C_IDLE : C_W4DATA;
            C_W4DATA:      state_d = (!F_MT && TX_RDY) ? C_STRT_SAMPLE : C_W4DATA;
            C_STRT_SAMPLE: state_d = C_READ;
            C_READ: begin
                if (seq_q == C_SEQ_LAST_DATA) begin
                    state_d = w_end_now ? C_TAIL_END : C_TAIL_NO_END;
                end else begin
                    state_d = C_READ;
                end
            end
            C_TAIL_END:    state_d = w_tail_done ? C_LAST_WORD : C_TAIL_END;
            C_TAIL_NO_END: state_d = w_tail_done ? C_W4DATA : C_TAIL_NO_END;
            C_LAST_WORD:   state_d = C_IDLE;
            default:       state_d = 3'bxxx;
        endcase

        samp_cnt_d = samp_cnt_q;
        end_flag_d = end_flag_q;
        if (state_d == C_IDLE) begin
            samp_cnt_d = '0;
            end_flag_d = 1'b0;
        end else begin
            if (w_tail_done) begin
                samp_cnt_d = samp_cnt_q + C_SCNT_ONE;
            end
            if (w_in_data && END_EVT) begin
                end_flag_d = 1'b1;
            end
        end
    end

    // A stalled word slot becomes a bubble that holds the last issued index.
    always_comb begin
        rd_d       = 1'b0;
        valid_d    = 1'b0;
        seq_d      = '0;
        clr_crc_d  = 1'b0;
        last_wrd_d = 1'b0;
        trunc_d    = 1'b0;
        case (state_d)
            C_W4DATA: clr_crc_d = (state_q != C_W4DATA);
            C_STRT_SAMPLE: begin
                rd_d    = 1'b1;
                valid_d = 1'b1;
            end
            C_READ: begin
                if (w_data_stall) begin
                    seq_d = seq_q;
                end else begin
                    rd_d    = 1'b1;
                    valid_d = 1'b1;
                    seq_d   = seq_q + C_SEQ_ONE;
                end
            end
            C_TAIL_END, C_TAIL_NO_END: begin
                if (TX_RDY) begin
                    valid_d = 1'b1;
                    seq_d   = seq_q + C_SEQ_ONE;
                end else begin
                    seq_d = seq_q;
                end
            end
            C_LAST_WORD: begin
                last_wrd_d = 1'b1;
                trunc_d    = !end_flag_q;
            end
            default: ;
        endcase
    end

    assign RD        = rd_q;
    assign VALID     = valid_q;
    assign SEQ       = seq_q;
    assign CLR_CRC   = clr_crc_q;
    assign LAST_WRD  = last_wrd_q;
    assign TRUNC     = trunc_q;
    assign SAMP_CNT  = samp_cnt_q;
    assign FRM_STATE = state_q;

endmodule
`default_nettype wire
